// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// A taken branch has priority over a jump, and either redirect has priority over a stall.
// PC arithmetic wraps modulo 2^32. Redirect targets are forced to word alignment, and
// AlignErr latches whenever a selected target had a nonzero low-order bit.
// Optional feature: define FETCH_PERF_COUNT_EN to add the FetchCount/StallCount outputs.
// Ports use big-endian bit numbering ([0:31], bit 31 is the LSB). Internal vectors are [31:0].
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [0:31] ReadAddress,
    input  logic [0:31] Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [0:31] BranchTarget,
    input  logic        Jump,
    input  logic [0:31] JumpTarget,
    output logic [0:31] IfIdInstruction,
    output logic [0:31] IfIdPcPlus4,
    output logic        IfIdValid,
`ifdef FETCH_PERF_COUNT_EN
    output logic [0:31] FetchCount,
    output logic [0:31] StallCount,
`endif
    output logic        AlignErr
);

    localparam logic [31:0] PcStep = 32'(PC_STEP);
    localparam logic [31:0] NopWord = 32'h0000_0000;

    // Little-endian internal copies of the big-endian ports; assignment preserves the value.
    logic [31:0] instr_word;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign instr_word = Instruction;
    assign branch_tgt = BranchTarget;
    assign jump_tgt   = JumpTarget;

    // Architectural state
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_plus_q, ifid_pc_plus_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        align_err_q, align_err_d;

    // Decoded control
    logic        redirect;
    logic [31:0] redir_raw;
    logic [31:0] redir_aligned;
    logic        redir_misaligned;
    logic [31:0] pc_plus_step;
    logic        load_valid;

    // Select the redirect source (branch wins over jump) and word-align it.
    always_comb begin
        redirect      = BranchTaken | Jump;
        redir_raw     = BranchTaken ? branch_tgt : jump_tgt;
        redir_aligned = {redir_raw[31:2], 2'b00};
        // Only a target that is actually selected may flag misalignment.
        redir_misaligned = redirect & (redir_raw[1:0] != 2'b00);
    end

    // Sequential increment; the 32-bit add wraps naturally.
    assign pc_plus_step = pc_q + PcStep;

    // IF/ID captures a real instruction only when nothing redirects, flushes or stalls.
    assign load_valid = ~redirect & ~Flush & ~Stall;

    // Next PC: redirect, else hold on stall, else step.
    always_comb begin
        pc_d = pc_plus_step;
        if (redirect) begin
            pc_d = redir_aligned;
        end else if (Stall) begin
            pc_d = pc_q;
        end
    end

    // Next IF/ID contents: bubble on redirect/flush, hold on stall, else capture.
    always_comb begin
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_plus_d = ifid_pc_plus_q;
        ifid_valid_d   = ifid_valid_q;
        if (redirect || Flush) begin
            ifid_instr_d   = NopWord;
            ifid_pc_plus_d = 32'h0000_0000;
            ifid_valid_d   = 1'b0;
        end else if (!Stall) begin
            ifid_instr_d   = instr_word;
            ifid_pc_plus_d = pc_plus_step;
            ifid_valid_d   = 1'b1;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_comb begin
        align_err_d = align_err_q | redir_misaligned;
    end

    // PC and IF/ID registers; reset discards any pending stall or redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            ifid_instr_q   <= NopWord;
            ifid_pc_plus_q <= 32'h0000_0000;
            ifid_valid_q   <= 1'b0;
            align_err_q    <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_plus_q <= ifid_pc_plus_d;
            ifid_valid_q   <= ifid_valid_d;
            align_err_q    <= align_err_d;
        end
    end

    // ReadAddress comes straight from the PC register: no combinational path from redirects.
    assign ReadAddress     = pc_q;
    assign IfIdInstruction = ifid_instr_q;
    assign IfIdPcPlus4     = ifid_pc_plus_q;
    assign IfIdValid       = ifid_valid_q;
    assign AlignErr        = align_err_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters: valid fetches, and stall cycles not overridden by a redirect.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_valid && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (Stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Two instances share the control inputs: one with the
// default RESET_PC and one starting at 32'hFFFFFFFC to exercise PC wrap-around. A behavioural
// model (per instance) predicts PC, IF/ID, AlignErr and, if FETCH_PERF_COUNT_EN is defined,
// the performance counters.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, br_taken, jump;
    logic [0:31] br_target, jump_target;

    logic [0:31] ra0, ra1, ins0, ins1, ifid_ins0, ifid_ins1, ifid_pp0, ifid_pp1;
    logic        ifid_v0, ifid_v1, ae0, ae1;
`ifdef FETCH_PERF_COUNT_EN
    logic [0:31] fc0, fc1, sc0, sc1;
`endif

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = default instance, 1 = wrap instance
    logic [31:0] m_pc[2];
    logic [31:0] m_ins[2];
    logic [31:0] m_pp[2];
    logic [31:0] m_v[2];
    logic [31:0] m_ae[2];
    logic [31:0] m_fc[2];
    logic [31:0] m_sc[2];
    logic [31:0] reset_pc[2];

    // Instruction memory contents: fixed words at 0 and 4, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2001_0005;
        if (a == 32'h4) return 32'h2002_0007;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign ins0 = mem_word(ra0);
    assign ins1 = mem_word(ra1);

    fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ReadAddress    (ra0),
        .Instruction    (ins0),
        .Stall          (stall),
        .Flush          (flush),
        .BranchTaken    (br_taken),
        .BranchTarget   (br_target),
        .Jump           (jump),
        .JumpTarget     (jump_target),
        .IfIdInstruction(ifid_ins0),
        .IfIdPcPlus4    (ifid_pp0),
        .IfIdValid      (ifid_v0),
`ifdef FETCH_PERF_COUNT_EN
        .FetchCount     (fc0),
        .StallCount     (sc0),
`endif
        .AlignErr       (ae0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .ReadAddress    (ra1),
        .Instruction    (ins1),
        .Stall          (stall),
        .Flush          (flush),
        .BranchTaken    (br_taken),
        .BranchTarget   (br_target),
        .Jump           (jump),
        .JumpTarget     (jump_target),
        .IfIdInstruction(ifid_ins1),
        .IfIdPcPlus4    (ifid_pp1),
        .IfIdValid      (ifid_v1),
`ifdef FETCH_PERF_COUNT_EN
        .FetchCount     (fc1),
        .StallCount     (sc1),
`endif
        .AlignErr       (ae1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]  = reset_pc[i];
            m_ins[i] = 32'h0;
            m_pp[i]  = 32'h0;
            m_v[i]   = 32'h0;
            m_ae[i]  = 32'h0;
            m_fc[i]  = 32'h0;
            m_sc[i]  = 32'h0;
        end
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ".ra0"}, ra0, m_pc[0]);
        check_eq({ctx, ".ra1"}, ra1, m_pc[1]);
        check_eq({ctx, ".ins0"}, ifid_ins0, m_ins[0]);
        check_eq({ctx, ".ins1"}, ifid_ins1, m_ins[1]);
        check_eq({ctx, ".pp0"}, ifid_pp0, m_pp[0]);
        check_eq({ctx, ".pp1"}, ifid_pp1, m_pp[1]);
        check_eq({ctx, ".v0"}, {31'b0, ifid_v0}, m_v[0]);
        check_eq({ctx, ".v1"}, {31'b0, ifid_v1}, m_v[1]);
        check_eq({ctx, ".ae0"}, {31'b0, ae0}, m_ae[0]);
        check_eq({ctx, ".ae1"}, {31'b0, ae1}, m_ae[1]);
`ifdef FETCH_PERF_COUNT_EN
        check_eq({ctx, ".fc0"}, fc0, m_fc[0]);
        check_eq({ctx, ".fc1"}, fc1, m_fc[1]);
        check_eq({ctx, ".sc0"}, sc0, m_sc[0]);
        check_eq({ctx, ".sc1"}, sc1, m_sc[1]);
`endif
    endtask

    // Drive one cycle of inputs, predict the outcome, clock once, then compare.
    task automatic step(input string ctx, input bit st, input bit fl, input bit bt,
                        input bit jp, input logic [31:0] btg, input logic [31:0] jtg);
        logic [31:0] n_pc[2], n_ins[2], n_pp[2], n_v[2], n_ae[2], n_fc[2], n_sc[2];
        logic [31:0] tgt;
        stall       = st;
        flush       = fl;
        br_taken    = bt;
        jump        = jp;
        br_target   = btg;
        jump_target = jtg;
        tgt = bt ? btg : jtg;
        for (int i = 0; i < 2; i++) begin
            n_ae[i] = m_ae[i];
            n_ins[i] = m_ins[i];
            n_pp[i]  = m_pp[i];
            n_v[i]   = m_v[i];
            n_fc[i]  = m_fc[i];
            n_sc[i]  = m_sc[i];
            if (bt || jp) begin
                n_pc[i] = tgt - (tgt % 4);
                if (tgt % 4 != 0) n_ae[i] = 32'h1;
            end else if (st) begin
                n_pc[i] = m_pc[i];
            end else begin
                n_pc[i] = m_pc[i] + 4;
            end
            if (bt || jp || fl) begin
                n_ins[i] = 32'h0;
                n_pp[i]  = 32'h0;
                n_v[i]   = 32'h0;
            end else if (!st) begin
                n_ins[i] = mem_word(m_pc[i]);
                n_pp[i]  = m_pc[i] + 4;
                n_v[i]   = 32'h1;
                if (m_fc[i] != 32'hFFFF_FFFF) n_fc[i] = m_fc[i] + 1;
            end
            if (st && !(bt || jp) && m_sc[i] != 32'hFFFF_FFFF) n_sc[i] = m_sc[i] + 1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_pc[i]  = n_pc[i];
            m_ins[i] = n_ins[i];
            m_pp[i]  = n_pp[i];
            m_v[i]   = n_v[i];
            m_ae[i]  = n_ae[i];
            m_fc[i]  = n_fc[i];
            m_sc[i]  = n_sc[i];
        end
        check_all(ctx);
    endtask

    // Pulse reset away from the clock edge; outputs must react before the next edge.
    task automatic async_reset(input string ctx);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq({ctx, ".ra0_async"}, ra0, 32'h0000_0000);
        check_eq({ctx, ".ra1_async"}, ra1, 32'hFFFF_FFFC);
        check_all(ctx);
        @(negedge clk);
        stall = 0; flush = 0; br_taken = 0; jump = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        reset_pc[0] = 32'h0000_0000;
        reset_pc[1] = 32'hFFFF_FFFC;
        rst_n = 1'b0;
        stall = 0; flush = 0; br_taken = 0; jump = 0;
        br_target = '0; jump_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset.ra0", ra0, 32'h0);
        check_eq("reset.ra1", ra1, 32'hFFFF_FFFC);
        check_all("reset");
        rst_n = 1'b1;

        // Sequential fetch from reset
        step("seq1", 0, 0, 0, 0, 0, 0);
        check_eq("seq1.ins", ifid_ins0, 32'h2001_0005);
        check_eq("seq1.pp", ifid_pp0, 32'h4);
        check_eq("seq1.v", {31'b0, ifid_v0}, 32'h1);
        check_eq("seq1.ra_wrap", ra1, 32'h0);
        step("seq2", 0, 0, 0, 0, 0, 0);
        check_eq("seq2.ra", ra0, 32'h8);
        check_eq("seq2.ins", ifid_ins0, 32'h2002_0007);
        check_eq("seq2.pp", ifid_pp0, 32'h8);

        // Two stall cycles at PC=8
        step("stall1", 1, 0, 0, 0, 0, 0);
        step("stall2", 1, 0, 0, 0, 0, 0);
        check_eq("stall.ra", ra0, 32'h8);
        check_eq("stall.ins", ifid_ins0, 32'h2002_0007);
`ifdef FETCH_PERF_COUNT_EN
        check_eq("stall.cnt", sc0, 32'h2);
`endif

        // Branch overrides stall
        step("br_stall", 1, 0, 1, 0, 32'h40, 0);
        check_eq("br_stall.ra", ra0, 32'h40);
        check_eq("br_stall.v", {31'b0, ifid_v0}, 32'h0);
        check_eq("br_stall.ins", ifid_ins0, 32'h0);

        // Branch beats jump
        step("br_jmp", 0, 0, 1, 1, 32'h10, 32'h20);
        check_eq("br_jmp.ra", ra0, 32'h10);

        // Flush alone inserts a bubble while PC advances
        step("flush", 0, 1, 0, 0, 0, 0);

        // Misaligned jump target
        step("jmp_mis", 0, 0, 0, 1, 32'h0, 32'h0000_00A6);
        check_eq("jmp_mis.ra", ra0, 32'hA4);
        check_eq("jmp_mis.ae", {31'b0, ae0}, 32'h1);
        for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 0, 0);
        check_eq("ae_sticky", {31'b0, ae0}, 32'h1);

        // Reset with a redirect and stall pending
        stall = 1; br_taken = 1; br_target = 32'h100;
        async_reset("rst_mid");
        step("post_rst", 0, 0, 0, 0, 0, 0);
        check_eq("post_rst.ins", ifid_ins0, 32'h2001_0005);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit st, fl, bt, jp;
            logic [31:0] btg, jtg;
            st  = ($urandom % 4) == 0;
            fl  = ($urandom % 10) == 0;
            bt  = ($urandom % 10) == 0;
            jp  = ($urandom % 10) == 0;
            btg = $urandom;
            jtg = $urandom;
            if (($urandom % 8) != 0) btg = btg & 32'hFFFF_FFFC;
            if (($urandom % 8) != 0) jtg = jtg & 32'hFFFF_FFFC;
            if (n == 200) begin
                stall = st; br_taken = 1; jump = jp;
                async_reset("rst_rand");
            end
            step("rand", st, fl, bt, jp, btg, jtg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
